mem_port_arbiter: RTL and testbench

- Shares the single pipelined Avalon-style memory port between the instruction-fetch master and the load/store data master.
- Selects one request per cycle and holds the grant stable while memory stalls.
- Tracks outstanding reads in an in-order owner-tag FIFO so each i_readdatavalid beat is returned to the master that issued the read.
- A starvation counter guarantees fetch progress under sustained data traffic.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: fetch master, data master and memory side.
// The arbiter takes the slave view; the environment (cores, memory) takes the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_word_bits = 32
);
    // Instruction-fetch master
    logic [p_addr_bits-1:0]   i_if_addr;
    logic                     i_if_read;
    logic                     o_if_waitrequest;
    logic [p_word_bits-1:0]   o_if_readdata;
    logic                     o_if_readdatavalid;

    // Load/store data master
    logic [p_addr_bits-1:0]   i_d_addr;
    logic                     i_d_read;
    logic                     i_d_write;
    logic [p_word_bits-1:0]   i_d_writedata;
    logic [p_word_bits/8-1:0] i_d_byteenable;
    logic                     o_d_waitrequest;
    logic [p_word_bits-1:0]   o_d_readdata;
    logic                     o_d_readdatavalid;

    // Memory port
    logic [p_addr_bits-1:0]   o_addr;
    logic                     o_read;
    logic                     o_write;
    logic [p_word_bits-1:0]   o_writedata;
    logic [p_word_bits/8-1:0] o_byteenable;
    logic [p_word_bits-1:0]   o_burstcount;
    logic                     i_waitrequest;
    logic [p_word_bits-1:0]   i_readdata;
    logic                     i_readdatavalid;

    modport slave (
        input  i_if_addr, i_if_read,
        output o_if_waitrequest, o_if_readdata, o_if_readdatavalid,
        input  i_d_addr, i_d_read, i_d_write, i_d_writedata, i_d_byteenable,
        output o_d_waitrequest, o_d_readdata, o_d_readdatavalid,
        output o_addr, o_read, o_write, o_writedata, o_byteenable, o_burstcount,
        input  i_waitrequest, i_readdata, i_readdatavalid
    );

    modport master (
        output i_if_addr, i_if_read,
        input  o_if_waitrequest, o_if_readdata, o_if_readdatavalid,
        output i_d_addr, i_d_read, i_d_write, i_d_writedata, i_d_byteenable,
        input  o_d_waitrequest, o_d_readdata, o_d_readdatavalid,
        input  o_addr, o_read, o_write, o_writedata, o_byteenable, o_burstcount,
        output i_waitrequest, i_readdata, i_readdatavalid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single pipelined Avalon-style memory port.
// Data wins by default; fetch is promoted once it has been blocked p_starve_limit cycles.
// A grant is held while memory stalls. Read ownership is tracked in an in-order tag FIFO
// so each returning beat is steered to the master that issued it.
module mem_port_arbiter #(
    parameter int unsigned p_addr_bits            = 32,
    parameter int unsigned p_word_bits            = 32,
    parameter int unsigned p_max_outstanding      = 8,
    parameter int unsigned p_max_outstanding_log2 = 3,
    parameter int unsigned p_starve_limit         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    mem_port_arbiter_if.slave               io_bus,
    output logic [p_max_outstanding_log2:0] o_outstanding,
    output logic                            o_err
);

    localparam int unsigned lp_cnt_bits    = p_max_outstanding_log2 + 1;
    localparam int unsigned lp_ptr_bits    = p_max_outstanding_log2;
    localparam int unsigned lp_starve_bits = $clog2(p_starve_limit + 1);
    localparam logic [lp_ptr_bits-1:0] lp_ptr_max = lp_ptr_bits'(p_max_outstanding - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_IF,
        ST_HOLD_D
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Tag FIFO: 0 = fetch owns the read, 1 = data owns it
    logic [p_max_outstanding-1:0] r_tags;
    logic [lp_ptr_bits-1:0]       r_wr_ptr;
    logic [lp_ptr_bits-1:0]       r_rd_ptr;
    logic [lp_cnt_bits-1:0]       r_count;
    logic [lp_starve_bits-1:0]    r_starve;
    logic                         r_err;

    logic                   w_rd_room;
    logic                   w_if_elig;
    logic                   w_d_elig;
    logic                   w_starved;
    logic                   w_gnt_if;
    logic                   w_gnt_d;
    logic                   w_read;
    logic                   w_if_acc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic                   w_head_tag;
    logic [p_addr_bits-1:0] w_addr;
    logic [lp_ptr_bits-1:0] w_wr_ptr_inc;
    logic [lp_ptr_bits-1:0] w_rd_ptr_inc;

    // A read needs a free tag slot; writes never occupy the FIFO
    assign w_rd_room = r_count < lp_cnt_bits'(p_max_outstanding);
    assign w_if_elig = io_bus.i_if_read & w_rd_room;
    assign w_d_elig  = (io_bus.i_d_read & w_rd_room) | io_bus.i_d_write;
    assign w_starved = r_starve == lp_starve_bits'(p_starve_limit);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a stalled grant is held; acceptance or a dropped request returns to idle
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_gnt_if && io_bus.i_waitrequest) begin
            w_state_next = ST_HOLD_IF;
        end else if (w_gnt_d && io_bus.i_waitrequest) begin
            w_state_next = ST_HOLD_D;
        end
    end

    // Grant decode; forced off during reset so no request leaks onto the memory port
    always_comb begin
        w_gnt_if = 1'b0;
        w_gnt_d  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_if_elig && (w_starved || !w_d_elig)) begin
                    w_gnt_if = 1'b1;
                end else if (w_d_elig) begin
                    w_gnt_d = 1'b1;
                end
            end
            ST_HOLD_IF: w_gnt_if = io_bus.i_if_read;
            ST_HOLD_D:  w_gnt_d  = io_bus.i_d_read | io_bus.i_d_write;
            default: begin
                w_gnt_if = 1'b0;
                w_gnt_d  = 1'b0;
            end
        endcase
        if (!rst) begin
            w_gnt_if = 1'b0;
            w_gnt_d  = 1'b0;
        end
    end

    // Zero-latency pass-through of the winner's request
    assign w_addr               = w_gnt_d ? io_bus.i_d_addr : io_bus.i_if_addr;
    assign w_read               = w_gnt_if | (w_gnt_d & io_bus.i_d_read);
    assign io_bus.o_addr        = w_addr;
    assign io_bus.o_read        = w_read;
    assign io_bus.o_write       = w_gnt_d & io_bus.i_d_write;
    assign io_bus.o_writedata   = io_bus.i_d_writedata;
    assign io_bus.o_byteenable  = io_bus.i_d_byteenable;
    assign io_bus.o_burstcount  = p_word_bits'(1);

    assign io_bus.o_if_waitrequest = !(w_gnt_if & !io_bus.i_waitrequest);
    assign io_bus.o_d_waitrequest  = !(w_gnt_d & !io_bus.i_waitrequest);

    assign w_if_acc = w_gnt_if & !io_bus.i_waitrequest;
    assign w_push   = w_read & !io_bus.i_waitrequest;

    // Read return: head tag steers the beat; a beat with no tag is dropped
    assign w_fifo_empty = r_count == '0;
    assign w_pop        = io_bus.i_readdatavalid & !w_fifo_empty;
    assign w_head_tag   = r_tags[r_rd_ptr];

    assign io_bus.o_if_readdata      = io_bus.i_readdata;
    assign io_bus.o_d_readdata       = io_bus.i_readdata;
    assign io_bus.o_if_readdatavalid = w_pop & !w_head_tag;
    assign io_bus.o_d_readdatavalid  = w_pop & w_head_tag;

    assign w_wr_ptr_inc = (r_wr_ptr == lp_ptr_max) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == lp_ptr_max) ? '0 : r_rd_ptr + 1'b1;

    // Tag FIFO: push the owner on each accepted read, pop on each returning beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_gnt_d;
                r_wr_ptr         <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts blocked fetch cycles, saturates, clears on fetch acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_if_acc) begin
            r_starve <= '0;
        end else if (io_bus.i_if_read && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Sticky error: read data arrived with no owner on record
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (io_bus.i_readdatavalid && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

    assign o_outstanding = r_count;
    assign o_err         = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch-only stream, contention with starvation
// promotion, stall hold, FIFO full, empty-FIFO error and asynchronous reset.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] outstanding;
    logic       err;
    int         n_checks;
    int         n_fail;

    mem_port_arbiter_if #(.p_addr_bits(32), .p_word_bits(32)) bus ();

    mem_port_arbiter #(
        .p_addr_bits            (32),
        .p_word_bits            (32),
        .p_max_outstanding      (8),
        .p_max_outstanding_log2 (3),
        .p_starve_limit         (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .io_bus        (bus),
        .o_outstanding (outstanding),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_if_addr       = '0;
        bus.i_if_read       = 1'b0;
        bus.i_d_addr        = '0;
        bus.i_d_read        = 1'b0;
        bus.i_d_write       = 1'b0;
        bus.i_d_writedata   = '0;
        bus.i_d_byteenable  = '0;
        bus.i_waitrequest   = 1'b0;
        bus.i_readdata      = '0;
        bus.i_readdatavalid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset: requests and a stray beat are all masked
        bus.i_if_read       = 1'b1;
        bus.i_d_read        = 1'b1;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("rst_read", bus.o_read, 0);
        chk("rst_write", bus.o_write, 0);
        chk("rst_if_wait", bus.o_if_waitrequest, 1);
        chk("rst_d_wait", bus.o_d_waitrequest, 1);
        chk("rst_if_rdv", bus.o_if_readdatavalid, 0);
        chk("rst_d_rdv", bus.o_d_readdatavalid, 0);
        chk("rst_out", outstanding, 0);
        tick();
        chk("rst_err", err, 0);
        idle();
        rst = 1'b1;
        tick();

        // Fetch alone, 2-cycle read latency
        bus.i_if_read = 1'b1;
        bus.i_if_addr = 32'h0;
        #1;
        chk("f1_read", bus.o_read, 1);
        chk("f1_addr", bus.o_addr, 32'h0);
        chk("f1_if_wait", bus.o_if_waitrequest, 0);
        chk("f1_d_wait", bus.o_d_waitrequest, 1);
        chk("f1_burst", bus.o_burstcount, 1);
        tick();
        chk("f1_out", outstanding, 1);
        bus.i_if_addr = 32'h4;
        #1;
        chk("f2_addr", bus.o_addr, 32'h4);
        chk("f2_if_wait", bus.o_if_waitrequest, 0);
        tick();
        chk("f2_out", outstanding, 2);
        bus.i_if_addr       = 32'h8;
        bus.i_readdatavalid = 1'b1;
        bus.i_readdata      = 32'h1000;
        #1;
        chk("f3_addr", bus.o_addr, 32'h8);
        chk("f3_if_rdv", bus.o_if_readdatavalid, 1);
        chk("f3_if_data", bus.o_if_readdata, 32'h1000);
        chk("f3_d_rdv", bus.o_d_readdatavalid, 0);
        tick();
        chk("f3_out", outstanding, 2);
        bus.i_if_read  = 1'b0;
        bus.i_readdata = 32'h1004;
        #1;
        chk("f4_read", bus.o_read, 0);
        chk("f4_if_rdv", bus.o_if_readdatavalid, 1);
        chk("f4_d_rdv", bus.o_d_readdatavalid, 0);
        tick();
        chk("f4_out", outstanding, 1);
        bus.i_readdata = 32'h1008;
        #1;
        chk("f5_if_rdv", bus.o_if_readdatavalid, 1);
        chk("f5_if_data", bus.o_if_readdata, 32'h1008);
        tick();
        chk("f5_out", outstanding, 0);
        idle();

        // Contention: grants D,D,D,D,I,D; beats return two cycles after each accept
        for (int i = 0; i < 8; i++) begin
            bus.i_if_read       = (i < 6);
            bus.i_d_read        = (i < 6);
            bus.i_if_addr       = 32'h100 + 32'(4 * i);
            bus.i_d_addr        = 32'h800 + 32'(4 * i);
            bus.i_readdatavalid = (i >= 2);
            bus.i_readdata      = 32'hA000 + 32'(i);
            #1;
            if (i < 6) begin
                chk("c_if_wait", bus.o_if_waitrequest, (i == 4) ? 0 : 1);
                chk("c_d_wait", bus.o_d_waitrequest, (i == 4) ? 1 : 0);
                chk("c_addr", bus.o_addr, (i == 4) ? bus.i_if_addr : bus.i_d_addr);
            end
            if (i >= 2) begin
                chk("c_if_rdv", bus.o_if_readdatavalid, (i == 6) ? 1 : 0);
                chk("c_d_rdv", bus.o_d_readdatavalid, (i == 6) ? 0 : 1);
            end
            tick();
            chk("c_out", outstanding, (i == 0) ? 1 : (i <= 5) ? 2 : (i == 6) ? 1 : 0);
        end
        idle();

        // Stall hold: starve counter is 1 here and reaches 4 while data is held
        bus.i_d_read      = 1'b1;
        bus.i_d_addr      = 32'h200;
        bus.i_waitrequest = 1'b1;
        #1;
        chk("s1_addr", bus.o_addr, 32'h200);
        chk("s1_read", bus.o_read, 1);
        chk("s1_d_wait", bus.o_d_waitrequest, 1);
        chk("s1_if_wait", bus.o_if_waitrequest, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.i_if_read = 1'b1;
            bus.i_if_addr = 32'h300;
            #1;
            chk("s_hold_addr", bus.o_addr, 32'h200);
            chk("s_hold_if_wait", bus.o_if_waitrequest, 1);
            chk("s_hold_d_wait", bus.o_d_waitrequest, 1);
            tick();
        end
        bus.i_waitrequest = 1'b0;
        #1;
        chk("s4_addr", bus.o_addr, 32'h200);
        chk("s4_d_wait", bus.o_d_waitrequest, 0);
        chk("s4_if_wait", bus.o_if_waitrequest, 1);
        tick();
        chk("s4_out", outstanding, 1);
        bus.i_d_addr = 32'h204;
        #1;
        chk("s5_addr", bus.o_addr, 32'h300);
        chk("s5_if_wait", bus.o_if_waitrequest, 0);
        chk("s5_d_wait", bus.o_d_waitrequest, 1);
        tick();
        chk("s5_out", outstanding, 2);
        idle();
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("s6_d_rdv", bus.o_d_readdatavalid, 1);
        chk("s6_if_rdv", bus.o_if_readdatavalid, 0);
        tick();
        #1;
        chk("s7_if_rdv", bus.o_if_readdatavalid, 1);
        chk("s7_d_rdv", bus.o_d_readdatavalid, 0);
        tick();
        chk("s7_out", outstanding, 0);
        idle();

        // FIFO full: eight fetch reads with no returns
        for (int i = 0; i < 8; i++) begin
            bus.i_if_read = 1'b1;
            bus.i_if_addr = 32'(64 * i);
            #1;
            chk("full_if_wait", bus.o_if_waitrequest, 0);
            tick();
            chk("full_out", outstanding, 32'(i + 1));
        end
        bus.i_d_write      = 1'b1;
        bus.i_d_addr       = 32'h400;
        bus.i_d_writedata  = 32'hDEADBEEF;
        bus.i_d_byteenable = 4'h5;
        #1;
        chk("full9_if_wait", bus.o_if_waitrequest, 1);
        chk("full9_read", bus.o_read, 0);
        chk("full9_write", bus.o_write, 1);
        chk("full9_d_wait", bus.o_d_waitrequest, 0);
        chk("full9_addr", bus.o_addr, 32'h400);
        chk("full9_wdata", bus.o_writedata, 32'hDEADBEEF);
        chk("full9_be", bus.o_byteenable, 4'h5);
        tick();
        chk("full9_out", outstanding, 8);
        bus.i_d_write       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("full10_if_rdv", bus.o_if_readdatavalid, 1);
        chk("full10_if_wait", bus.o_if_waitrequest, 1);
        tick();
        chk("full10_out", outstanding, 7);
        bus.i_readdatavalid = 1'b0;
        #1;
        chk("full11_if_wait", bus.o_if_waitrequest, 0);
        tick();
        chk("full11_out", outstanding, 8);
        bus.i_if_read       = 1'b0;
        bus.i_readdatavalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_if_rdv", bus.o_if_readdatavalid, 1);
            tick();
        end
        chk("drain_out", outstanding, 0);
        idle();

        // Beat with empty FIFO: dropped, sticky error
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("e_if_rdv", bus.o_if_readdatavalid, 0);
        chk("e_d_rdv", bus.o_d_readdatavalid, 0);
        tick();
        chk("e_err", err, 1);
        bus.i_readdatavalid = 1'b0;
        tick();
        chk("e_err_sticky", err, 1);

        // Asynchronous reset mid-burst, then an orphan beat after release
        bus.i_if_read = 1'b1;
        tick();
        tick();
        chk("r_out_pre", outstanding, 2);
        #1;
        chk("r_read_pre", bus.o_read, 1);
        rst = 1'b0;
        #1;
        chk("r_read", bus.o_read, 0);
        chk("r_if_wait", bus.o_if_waitrequest, 1);
        chk("r_d_wait", bus.o_d_waitrequest, 1);
        chk("r_out", outstanding, 0);
        chk("r_err", err, 0);
        bus.i_if_read = 1'b0;
        tick();
        rst = 1'b1;
        bus.i_readdatavalid = 1'b1;
        #1;
        chk("r_orphan_rdv", bus.o_if_readdatavalid, 0);
        tick();
        chk("r_orphan_err", err, 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
